// File: rtl/mod47_inv_if.sv
// mod47_inv_if: valid/ready bundle for the mod-47 modular-inverse unit.
//
// Signals:
//   in_valid   producer -> unit   operand valid
//   in_ready   unit -> producer   unit can accept an operand
//   in_data    producer -> unit   operand a (W bits)
//   out_valid  unit -> consumer   result valid
//   out_ready  consumer -> unit   consumer accepts the result
//   out_data   unit -> consumer   a^-1 mod MOD (W bits)
//   out_err    unit -> consumer   operand was not invertible
//   out_chk    unit -> consumer   self-check failure flag
//
// Modports: slave = the inverse unit, master = the surrounding logic.
interface mod47_inv_if #(
    parameter int W = 6
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_err;
    logic         out_chk;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err, out_chk
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err, out_chk
    );
endinterface

// File: rtl/mod47_inv_seq.sv
// mod47_inv_seq: sequential modular inverse a^-1 mod MOD via Fermat
// exponentiation a^(MOD-2), left-to-right square-and-multiply, one modular
// multiply per cycle.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   mod47_inv_if.slave: in_valid/in_ready/in_data operand handshake,
//         out_valid/out_ready/out_data/out_err/out_chk result handshake
//
// Optional feature (macro MOD47_INV_SELFCHECK_EN): adds a CHK state after the
// last compute cycle that multiplies the result by the operand and raises
// out_chk when the product is not 1. Without the macro out_chk is tied to 0.
module mod47_inv_seq #(
    parameter int MOD = 47,
    parameter int W   = 6
) (
    input  logic            clk,
    input  logic            rst,
    mod47_inv_if.slave      bus
);
    localparam int EXP = MOD - 2;
    localparam int EW  = $clog2(EXP + 1);
    // For MOD=3 (EW=1) the single square+multiply yields a^3 == a == a^-1,
    // so starting at index 0 is still correct.
    localparam int IDX_START = (EW >= 2) ? EW - 2 : 0;
    localparam int IW        = (EW > 1) ? $clog2(EW) : 1;

    localparam logic [W-1:0]  MOD_W = W'(MOD);
    localparam logic [EW-1:0] EXP_V = EW'(EXP);
    localparam logic [W-1:0]  ONE_W = W'(1);

`ifdef MOD47_INV_SELFCHECK_EN
    typedef enum logic [2:0] {IDLE, SQ, MUL, CHK, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SQ, MUL, DONE} state_t;
`endif

    // Full 2W-bit product reduced into [0, MOD-1].
    function automatic logic [W-1:0] mod_mul(input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        logic [2*W-1:0] p;
        logic [2*W-1:0] r;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        r = p % (2*W)'(MOD);
        return r[W-1:0];
    endfunction

    state_t        state;
    logic [W-1:0]  acc;
    logic [W-1:0]  base;
    logic [IW-1:0] idx;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [W-1:0]  out_data_r;
    logic          out_err_r;
    logic [W-1:0]  mul_b;
    logic [W-1:0]  prod;

    // SQ squares the accumulator; MUL (and CHK) multiply by the operand.
    assign mul_b = (state == SQ) ? acc : base;
    assign prod  = mod_mul(acc, mul_b);

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_err   = out_err_r;

`ifdef MOD47_INV_SELFCHECK_EN
    logic out_chk_r;
    assign bus.out_chk = out_chk_r;
`else
    assign bus.out_chk = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            base        <= '0;
            idx         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_err_r   <= 1'b0;
`ifdef MOD47_INV_SELFCHECK_EN
            out_chk_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        base       <= bus.in_data;
                        in_ready_r <= 1'b0;
`ifdef MOD47_INV_SELFCHECK_EN
                        out_chk_r  <= 1'b0;
`endif
                        if (bus.in_data == '0 || bus.in_data >= MOD_W) begin
                            acc         <= '0;
                            out_data_r  <= '0;
                            out_err_r   <= 1'b1;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            acc       <= bus.in_data;
                            idx       <= IW'(IDX_START);
                            out_err_r <= 1'b0;
                            state     <= SQ;
                        end
                    end
                end
                SQ: begin
                    acc <= prod;
                    if (EXP_V[idx]) begin
                        state <= MUL;
                    end else if (idx == '0) begin
`ifdef MOD47_INV_SELFCHECK_EN
                        state       <= CHK;
`else
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                        out_data_r  <= prod;
`endif
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                MUL: begin
                    acc <= prod;
                    if (idx == '0) begin
`ifdef MOD47_INV_SELFCHECK_EN
                        state       <= CHK;
`else
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                        out_data_r  <= prod;
`endif
                    end else begin
                        idx   <= idx - 1'b1;
                        state <= SQ;
                    end
                end
`ifdef MOD47_INV_SELFCHECK_EN
                CHK: begin
                    // prod here is acc*base: a correct inverse gives 1.
                    out_chk_r   <= (prod != ONE_W);
                    out_data_r  <= acc;
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
`endif
                DONE: begin
                    // Result and flags hold while the consumer stalls.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mod47_inv_seq.md
Name: mod47_inv_seq

Overview:
- Sequential modular-inverse unit for the mod-47 datapath. It is the decode direction of the constant-multiplier LUT blocks: it undoes a multiplication by computing a^-1 mod 47 through Fermat exponentiation, a^(MOD-2).
- It uses left-to-right square-and-multiply with one modular multiply per cycle.
- It sits between residue producers and consumers and uses valid/ready handshakes on both sides.

Parameters:
- MOD, 47: prime modulus. Must satisfy 3 <= MOD < 2^W.
- W, 6: residue width in bits.
- EXP, MOD-2: exponent, derived and not overridden. Its bit-length is EW; for the defaults, EXP = 45 = 101101b and EW = 6.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  unit can accept an operand.
- in_data  in  W  operand a.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  W  result, a^-1 mod MOD.
- out_err  out  1  operand was not invertible (a == 0 or a >= MOD).
- out_chk  out  1  self-check failure flag (see Optional Feature).

Behaviour:
- Reset: clk is the single clock. rst is asynchronous and active-high, and forces state=IDLE, in_ready=1, out_valid=0, out_data=0, out_err=0, out_chk=0, acc=0, base=0, bit index=0.
- States: IDLE, SQ, MUL, DONE. in_ready=1 only in IDLE.
- IDLE: an input handshake (in_valid & in_ready) latches base=in_data.
  - If in_data==0 or in_data>=MOD: go to DONE with out_data=0 and out_err=1.
  - Otherwise: acc=in_data, idx=EW-2, out_err=0, go to SQ.
- SQ: acc = acc*acc mod MOD.
  - If EXP[idx]==1, go to MUL.
  - Otherwise, if idx==0 go to DONE; else idx-- and stay in SQ.
- MUL: acc = acc*base mod MOD. Then, if idx==0 go to DONE; else idx-- and go to SQ.
- Arithmetic: full 2W-bit product reduced to [0, MOD-1]. Intermediate acc is never >= MOD.
- Latency: fixed for a given MOD.
  - For MOD=47: 5 SQ + 3 MUL = 8 compute cycles. out_valid is high in the 9th cycle after the accept edge, i.e. 8 edges after the accept edge.
  - Error operands: out_valid is high in the cycle after the accept edge.
- DONE: out_valid=1, with out_data=acc registered.
  - out_data and out_err are held stable while out_valid & !out_ready (backpressure; no timeout).
  - On out_valid & out_ready: go to IDLE with out_valid=0. in_ready rises the following cycle, so there is no same-cycle accept in DONE.
  - Peak throughput is one result per 10 cycles.
- in_data changing while not accepted is ignored.
- rst asserted mid-computation aborts the operation immediately. No result is emitted, and the state returns to IDLE.

Optional Feature:
- Macro: MOD47_INV_SELFCHECK_EN.
- When defined:
  - One extra state, CHK, sits between the last compute cycle and DONE.
  - CHK computes acc*base mod MOD and sets out_chk=1 if the result != 1. Error operands skip CHK and keep out_chk=0.
  - Latency for valid operands becomes 9 compute cycles.
- When undefined:
  - No CHK state or checker multiplier exists.
  - out_chk is tied to 0 and latency is as above.

Test Plan:
- Reset, then operand a=2 (in_valid=1 for 1 cycle), out_ready=1 -> out_valid rises 8 edges after the accept edge; out_data=24, out_err=0, out_chk=0; in_ready returns 1 one cycle after the output handshake.
- Sequence a=1, 3, 5, 46 -> out_data=1, 16, 19, 46 respectively. Sweep all a=1..46 and check (a*out_data) mod 47 == 1.
- a=0, then a=50 -> each gives out_valid after 1 cycle, out_err=1, out_data=0, no compute states entered.
- a=3 with out_ready held 0 for 20 cycles -> out_valid stays 1, out_data=16 stable, in_ready=0 throughout; out_ready=1 completes the transfer and out_valid drops next cycle.
- Assert rst asynchronously 4 cycles after accepting a=7 -> outputs go to reset values immediately, with no out_valid. Then a=7 -> out_data=27 (7*27=189=4*47+1).
- With MOD47_INV_SELFCHECK_EN defined: a=2 -> out_data=24, out_chk=0, out_valid 9 edges after accept. Force the acc register corrupt in CHK via bench hook -> out_chk=1.
